// File: rtl/imem_fetch_bank.sv
// imem_fetch_bank: N-wide instruction memory with registered read, 2-entry response FIFO, flush and program-load port
module imem_fetch_bank #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 10,
  parameter int WRAP = 1,
  parameter INIT_FILE = ""
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic flush,
  output logic resp_valid,
  input  logic resp_ready,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [32*FETCH_WIDTH-1:0] resp_instr,
  output logic [FETCH_WIDTH-1:0] resp_mask,
  input  logic prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0] prog_data
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] mem [DEPTH];
  logic [32*FETCH_WIDTH-1:0] rd_instr;
  logic [FETCH_WIDTH-1:0] rd_mask;
  logic [ADDR_W-1:0] q_addr [2];
  logic [32*FETCH_WIDTH-1:0] q_instr [2];
  logic [FETCH_WIDTH-1:0] q_mask [2];
  logic rd_ptr, wr_ptr, push, pop;
  logic [1:0] count;
  initial
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP;
  always_ff @(posedge clk)
    if (prog_we) mem[prog_addr] <= prog_data;
  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    logic [ADDR_W:0] sum;
    assign sum = {1'b0, req_addr} + (ADDR_W+1)'(k);
    assign rd_mask[k] = (WRAP != 0) || !sum[ADDR_W];
    assign rd_instr[32*k +: 32] = rd_mask[k] ? mem[sum[ADDR_W-1:0]] : NOP;
  end
  assign req_ready = !rst && !flush && (count != 2'd2);
  assign push = req_valid && req_ready;
  assign resp_valid = count != 2'd0;
  assign pop = resp_valid && resp_ready;
  assign resp_addr = resp_valid ? q_addr[rd_ptr] : '0;
  assign resp_instr = resp_valid ? q_instr[rd_ptr] : {FETCH_WIDTH{NOP}};
  assign resp_mask = resp_valid ? q_mask[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wr_ptr] <= req_addr;
      q_instr[wr_ptr] <= rd_instr;
      q_mask[wr_ptr] <= rd_mask;
    end
  always_ff @(posedge clk)
    if (rst || flush) begin
      count <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule
